// File: rtl/unidade_controle_pkg.sv
// unidade_controle_pkg: shared state/class enums, IR field layout and extender mode codes
package unidade_controle_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERRO
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_LIT,
        C_LCH,
        C_JMP,
        C_MEM
    } iclass_t;

    // Only IR[15:11] steers control; the rest is operand data for the datapath.
    localparam int CTL_LSB = 11;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LIT = 2'b01;
    localparam logic [1:0] OP_LCH = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;
    localparam logic [1:0] FN_MEM = 2'b11;

    localparam logic [2:0] EXT_NONE    = 3'b000;
    localparam logic [2:0] EXT_LCH_LO  = 3'b001;
    localparam logic [2:0] EXT_LCH_HI  = 3'b010;
    localparam logic [2:0] EXT_JMP_FI  = 3'b011;
    localparam logic [2:0] EXT_JMP_FII = 3'b100;

endpackage

// File: rtl/unidade_controle_decodificador.sv
// unidade_controle_decodificador: combinational IR -> instruction class and extender mode
module unidade_controle_decodificador
    import unidade_controle_pkg::*;
(
    input  logic [15:CTL_LSB] i_ir,
    output iclass_t           o_class,
    output logic              o_store,
    output logic              o_fii,
    output logic [2:0]        o_ext
);

    logic [1:0] w_op;
    logic [1:0] w_fn;

    assign w_op    = i_ir[15:14];
    assign w_fn    = i_ir[13:12];
    assign o_store = i_ir[11];
    assign o_fii   = i_ir[13];

    assign o_class = w_op == OP_LIT ? C_LIT :
                     w_op == OP_LCH ? C_LCH :
                     w_op == OP_JMP ? C_JMP :
                     (w_op == OP_ALU && w_fn == FN_MEM) ? C_MEM : C_ALU;

    assign o_ext = o_class == C_LCH ? (i_ir[11] ? EXT_LCH_HI : EXT_LCH_LO) :
                   o_class == C_JMP ? (o_fii ? EXT_JMP_FII : EXT_JMP_FI) : EXT_NONE;

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit FSM with memory-ack timeout and sticky error
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_instr,
    input  logic        i_imem_ack,
    input  logic        i_dmem_ack,
    input  logic        i_cond_true,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic        o_pc_sel,
    output logic        o_reg_we,
    output logic [2:0]  o_ext_ctrl,
    output logic        o_imm_sel,
    output logic        o_erro
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_active;
    logic [15:CTL_LSB]   r_ir;
    logic [CW-1:0]       r_cnt;
    iclass_t             w_class;
    logic                w_store;
    logic                w_fii;
    logic                w_wait;
    logic                w_expired;
    logic                w_unused_operand;

    assign w_unused_operand = ^i_instr[CTL_LSB-1:0];

    unidade_controle_decodificador u_dec (
        .i_ir    (r_ir),
        .o_class (w_class),
        .o_store (w_store),
        .o_fii   (w_fii),
        .o_ext   (o_ext_ctrl)
    );

    // r_active keeps every output low until the first edge after reset release.
    assign w_wait    = r_active && ((r_state == S_FETCH && !i_imem_ack) || (r_state == S_MEM && !i_dmem_ack));
    assign w_expired = r_cnt == CW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_active <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir  <= '0;
            r_cnt <= '0;
        end else begin
            if (o_ir_we) r_ir <= i_instr[15:CTL_LSB];
            r_cnt <= (w_next != r_state) ? '0 : w_wait ? r_cnt + 1'b1 : r_cnt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (r_active) w_next = i_imem_ack ? S_DECODE : w_expired ? S_ERRO : S_FETCH;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = w_class == C_JMP ? S_FETCH : w_class == C_MEM ? S_MEM : S_WB;
            S_MEM:    w_next = i_dmem_ack ? (w_store ? S_FETCH : S_WB) : w_expired ? S_ERRO : S_MEM;
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_ERRO;
        endcase
    end

    always_comb begin
        o_imem_req = 1'b0;
        o_ir_we    = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_pc_we    = 1'b0;
        o_pc_sel   = 1'b0;
        o_reg_we   = 1'b0;
        o_imm_sel  = 1'b0;
        o_erro     = r_state == S_ERRO;
        case (r_state)
            S_FETCH: begin
                o_imem_req = r_active && !i_imem_ack;
                o_ir_we    = r_active && i_imem_ack;
            end
            S_EXEC: begin
                o_pc_we  = w_class == C_JMP;
                o_pc_sel = w_class == C_JMP && (w_fii || i_cond_true);
            end
            S_MEM: begin
                o_dmem_req = !i_dmem_ack;
                o_dmem_we  = !i_dmem_ack && w_store;
                o_pc_we    = i_dmem_ack && w_store;
            end
            S_WB: begin
                o_reg_we  = 1'b1;
                o_pc_we   = 1'b1;
                o_imm_sel = w_class == C_LIT || w_class == C_LCH;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: random and directed instruction streams checked cycle by cycle against a transaction model
module tb_unidade_controle;

    localparam int TO = 15;

    localparam logic [8:0] F_IREQ  = 9'b100000000;
    localparam logic [8:0] F_IRWE  = 9'b010000000;
    localparam logic [8:0] F_DREQ  = 9'b001000000;
    localparam logic [8:0] F_DWE   = 9'b000100000;
    localparam logic [8:0] F_PCWE  = 9'b000010000;
    localparam logic [8:0] F_PCSEL = 9'b000001000;
    localparam logic [8:0] F_REGWE = 9'b000000100;
    localparam logic [8:0] F_IMM   = 9'b000000010;
    localparam logic [8:0] F_ERR   = 9'b000000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] instr = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        cond_true = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, imm_sel, erro;
    logic [2:0]  ext_ctrl;
    logic [11:0] vec;

    int          total = 0;
    int          bad = 0;
    logic [2:0]  m_ext = '0;
    bit          m_stray = 1'b0;

    always #5 clk = ~clk;

    unidade_controle #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_instr     (instr),
        .i_imem_ack  (imem_ack),
        .i_dmem_ack  (dmem_ack),
        .i_cond_true (cond_true),
        .o_imem_req  (imem_req),
        .o_dmem_req  (dmem_req),
        .o_dmem_we   (dmem_we),
        .o_ir_we     (ir_we),
        .o_pc_we     (pc_we),
        .o_pc_sel    (pc_sel),
        .o_reg_we    (reg_we),
        .o_ext_ctrl  (ext_ctrl),
        .o_imm_sel   (imm_sel),
        .o_erro      (erro)
    );

    assign vec = {ext_ctrl, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we, imm_sel, erro};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic bit sa();
        return m_stray && ($urandom_range(3) == 0);
    endfunction

    // Entered at posedge+1: drive, sample at the falling edge, advance to next posedge+1.
    task automatic cyc(input bit ia, input bit da, input bit ct, input logic [11:0] exp, input string tag);
        imem_ack  = ia;
        dmem_ack  = da;
        cond_true = ct;
        #4;
        check(tag, 32'(vec), 32'(exp));
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_async", 32'(vec), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #4;
        check("rst_release", 32'(vec), 32'd0);
        @(posedge clk);
        #1;
        m_ext = '0;
    endtask

    // One instruction: fd/md = cycles the fetch/data ack is withheld; >= TO means it never comes.
    task automatic run_instr(input logic [15:0] ins, input int fd, input int md, input bit ct);
        logic [1:0] op;
        logic [2:0] e;
        logic [2:0] eo;
        bit jmp, mem, str, konst, tk;
        instr = ins;
        eo    = m_ext;
        op    = ins[15:14];
        e     = op == 2'b01 ? 3'd0 : op == 2'b10 ? (ins[11] ? 3'd2 : 3'd1) :
                op == 2'b11 ? (ins[13] ? 3'd4 : 3'd3) : 3'd0;
        jmp   = op == 2'b11;
        mem   = op == 2'b00 && ins[13:12] == 2'b11;
        str   = ins[11];
        konst = op == 2'b01 || op == 2'b10;
        tk    = ins[13] || ct;
        for (int w = 0; w < fd && w < TO; w++) cyc(1'b0, sa(), ct, {eo, F_IREQ}, "fetch_wait");
        if (fd >= TO) return;
        cyc(1'b1, sa(), ct, {eo, F_IRWE}, "fetch_ack");
        m_ext = e;
        cyc(sa(), sa(), ct, {e, 9'd0}, "decode");
        if (jmp) begin
            cyc(sa(), sa(), ct, {e, F_PCWE | (tk ? F_PCSEL : 9'd0)}, "exec_jump");
            return;
        end
        cyc(sa(), sa(), ct, {e, 9'd0}, "exec");
        if (mem) begin
            for (int w = 0; w < md && w < TO; w++) cyc(sa(), 1'b0, ct, {e, F_DREQ | (str ? F_DWE : 9'd0)}, "mem_wait");
            if (md >= TO) return;
            cyc(sa(), 1'b1, ct, {e, str ? F_PCWE : 9'd0}, "mem_ack");
            if (str) return;
        end
        cyc(sa(), sa(), ct, {e, F_REGWE | F_PCWE | (konst ? F_IMM : 9'd0)}, "wb");
    endtask

    task automatic err_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            instr = 16'($urandom);
            cyc(1'($urandom), 1'($urandom), 1'($urandom), {m_ext, F_ERR}, "erro_hold");
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        run_instr(16'h4123, 2, 0, 1'b0);
        run_instr(16'h88AB, 0, 0, 1'b0);
        run_instr(16'h80CD, 1, 0, 1'b0);
        run_instr(16'hC0F0, 0, 0, 1'b0);
        run_instr(16'hC0F0, 0, 0, 1'b1);
        run_instr(16'hE800, 0, 0, 1'b0);
        run_instr(16'h3800, 1, 3, 1'b0);
        run_instr(16'h3000, 0, 2, 1'b0);
        run_instr(16'h1234, 0, 0, 1'b0);
        m_stray = 1'b1;
        repeat (60) run_instr(16'($urandom), int'($urandom_range(4)), int'($urandom_range(4)), 1'($urandom));
        run_instr(16'h4001, TO - 1, 0, 1'b0);
        run_instr(16'h3800, 0, TO - 1, 1'b0);
        run_instr(16'h88AB, TO, 0, 1'b0);
        err_cycles(5);
        do_reset();
        run_instr(16'h3000, 0, TO, 1'b0);
        err_cycles(3);
        do_reset();
        instr = 16'h3800;
        cyc(1'b1, 1'b0, 1'b0, {m_ext, F_IRWE}, "mid_ack");
        cyc(1'b0, 1'b0, 1'b0, {3'd0, 9'd0}, "mid_decode");
        cyc(1'b0, 1'b0, 1'b0, {3'd0, 9'd0}, "mid_exec");
        cyc(1'b0, 1'b0, 1'b0, {3'd0, F_DREQ | F_DWE}, "mid_mem");
        do_reset();
        run_instr(16'h88AB, 0, 0, 1'b0);
        run_instr(16'hC0F0, 3, 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
